// File: rtl/rr_arb_mux_4_1_if.sv
// rtl/rr_arb_mux_4_1_if.sv - lane and output handshake bundle for the 4-lane round-robin arbiter mux
interface rr_arb_mux_4_1_if #(
  parameter int WIDTH = 4
);
  // Producer lanes: bit i of in_valid/in_ready belongs to lane i
  logic [3:0]       in_valid;
  logic [3:0]       in_ready;
  logic [WIDTH-1:0] d0;
  logic [WIDTH-1:0] d1;
  logic [WIDTH-1:0] d2;
  logic [WIDTH-1:0] d3;

  // Merged output stream, tagged with the supplying lane
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       out_sel;

  // Environment side: drives lanes and the consumer ready
  modport master (
    output in_valid, d0, d1, d2, d3, out_ready,
    input  in_ready, out_valid, out_data, out_sel
  );

  // Arbiter side
  modport slave (
    input  in_valid, d0, d1, d2, d3, out_ready,
    output in_ready, out_valid, out_data, out_sel
  );
endinterface

// File: rtl/rr_arb_mux_4_1.sv
// rtl/rr_arb_mux_4_1.sv - 4-lane round-robin arbiter with registered 4:1 data mux and lane tag
module rr_arb_mux_4_1 #(
  parameter int WIDTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  rr_arb_mux_4_1_if.slave     bus
);

  logic [1:0]       ptr;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;
  logic [1:0]       out_sel_q;

  logic             load_en;
  logic             grant_vld;
  logic [1:0]       grant_idx;
  logic             transfer;
  logic [WIDTH-1:0] sel_data;

  // Output register can take a new beat when empty or being drained this cycle
  assign load_en = ~out_valid_q | bus.out_ready;

  // Rotating priority scan: lane ptr first, then ptr+1.. modulo 4; highest offset
  // is evaluated first so the lowest offset with a valid lane wins
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (bus.in_valid[ptr + 2'(k)]) begin
        grant_vld = 1'b1;
        grant_idx = ptr + 2'(k);
      end
    end
  end

  // Only the granted lane sees ready, and never while reset is held
  always_comb begin
    bus.in_ready = 4'b0000;
    if (grant_vld && load_en && !rst) begin
      bus.in_ready[grant_idx] = 1'b1;
    end
  end

  assign transfer = grant_vld & load_en & ~rst;

  // Index-driven mux so a non-granted lane's data (even X) never reaches the register
  always_comb begin
    sel_data = bus.d0;
    case (grant_idx)
      2'd0:    sel_data = bus.d0;
      2'd1:    sel_data = bus.d1;
      2'd2:    sel_data = bus.d2;
      2'd3:    sel_data = bus.d3;
      default: sel_data = bus.d0;
    endcase
  end

  // Output stage and priority pointer; pointer moves only on a lane transfer
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= 2'd0;
      ptr         <= 2'd0;
    end else if (transfer) begin
      out_valid_q <= 1'b1;
      out_data_q  <= sel_data;
      out_sel_q   <= grant_idx;
      ptr         <= grant_idx + 2'd1;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sel   = out_sel_q;

endmodule
